// File: rtl/lsu_mem_bridge.sv
// -----------------------------------------------------------------------------
// lsu_mem_bridge
//   Bridges the core LSU request/response handshake to the memory block's
//   ce/busy/valid protocol. Each accepted request is alignment-checked, then
//   issued as a single access. The access is closed on mem_fault, mem_valid,
//   a busy fall, or a timeout. A one-cycle response carries the read data and
//   a fault code.
//
// Parameters
//   TIMEOUT_CYCLES : maximum number of WAIT cycles before a timeout fault
//                    (0 disables the timeout)
//
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_write/funct3/addr/wdata : request attributes
//   rsp_valid            : one-cycle response strobe
//   rsp_rdata/rsp_fault  : response payload, held until the next response
//                          (fault codes: 0 ok, 1 misaligned, 2 access, 3 timeout)
//   mem_ce               : memory chip enable, active low
//   mem_funct3/addr/datain/memwrite : registered request copy to memory
//   mem_dataout/busy/valid/fault    : memory status and read data
// -----------------------------------------------------------------------------
module lsu_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_fault,
    output logic        mem_ce,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        mem_memwrite,
    input  logic [31:0] mem_dataout,
    input  logic        mem_busy,
    input  logic        mem_valid,
    input  logic        mem_fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] FAULT_OK      = 2'd0;
    localparam logic [1:0] FAULT_MISALGN = 2'd1;
    localparam logic [1:0] FAULT_ACCESS  = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

    // Timer only needs to reach TIMEOUT_CYCLES-1; it saturates at all ones.
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

    state_t         state_r;
    logic [TW-1:0]  timer_r;
    logic           seen_busy_r;
    logic           timeout_s;
    logic           misaligned_s;

    // Alignment rule by access size (funct3[1:0]); size 3 has no legal alignment.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (f3[1:0])
            2'b00:   m = 1'b0;
            2'b01:   m = a[0];
            2'b10:   m = (a != 2'b00);
            2'b11:   m = 1'b1;
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    // Alignment check on the incoming request and timeout detection.
    always_comb begin
        misaligned_s = is_misaligned(req_funct3, req_addr[1:0]);
        if (TIMEOUT_CYCLES != 0) begin
            timeout_s = (timer_r == TIMER_LAST);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Bridge FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            timer_r      <= {TW{1'b0}};
            seen_busy_r  <= 1'b0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0000_0000;
            rsp_fault    <= FAULT_OK;
            mem_ce       <= 1'b1;
            mem_funct3   <= 3'b000;
            mem_addr     <= 32'h0000_0000;
            mem_datain   <= 32'h0000_0000;
            mem_memwrite <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // req_ready is registered, so it rises one cycle after reset release.
                    req_ready <= 1'b1;
                    mem_ce    <= 1'b1;
                    rsp_valid <= 1'b0;
                    if (req_ready && req_valid) begin
                        mem_funct3   <= req_funct3;
                        mem_addr     <= req_addr;
                        mem_datain   <= req_wdata;
                        mem_memwrite <= req_write;
                        req_ready    <= 1'b0;
                        if (misaligned_s) begin
                            // Memory is never touched: respond directly.
                            state_r   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_fault <= FAULT_MISALGN;
                            rsp_rdata <= 32'h0000_0000;
                        end else begin
                            state_r <= ST_ISSUE;
                            mem_ce  <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    seen_busy_r <= 1'b0;
                    timer_r     <= {TW{1'b0}};
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_busy) begin
                        seen_busy_r <= 1'b1;
                    end
                    if (timer_r != TIMER_MAX) begin
                        timer_r <= timer_r + TW'(1);
                    end
                    if (mem_fault) begin
                        state_r   <= ST_RESP;
                        mem_ce    <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_fault <= FAULT_ACCESS;
                        rsp_rdata <= 32'h0000_0000;
                    end else if (mem_valid) begin
                        state_r   <= ST_RESP;
                        mem_ce    <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_fault <= FAULT_OK;
                        rsp_rdata <= mem_dataout;
                    end else if (seen_busy_r && !mem_busy) begin
                        // Register-style reads complete on busy fall without valid.
                        state_r   <= ST_RESP;
                        mem_ce    <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_fault <= FAULT_OK;
                        rsp_rdata <= mem_memwrite ? 32'h0000_0000 : mem_dataout;
                    end else if (timeout_s) begin
                        state_r   <= ST_RESP;
                        mem_ce    <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_fault <= FAULT_TIMEOUT;
                        rsp_rdata <= 32'h0000_0000;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    // The response cycle plus the following IDLE keep ce high for two cycles.
                    rsp_valid <= 1'b0;
                    mem_ce    <= 1'b1;
                    req_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_ce    <= 1'b1;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
